// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one result bit per cycle, with start/busy/valid and kill.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  // state | meaning
  // IDLE  | waiting for start; operands sampled here
  // CALC  | one shift-add / restoring-subtract iteration per edge
  // FIX   | sign correction, half/quotient/remainder select, result registered
  // DONE  | valid strobe cycle; returns to IDLE
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [CNTW-1:0] LAST_ITER = CNTW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic [2:0]          op_q;
  logic                neg_q;
  logic [XLEN-1:0]     b_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [CNTW-1:0]     cnt_q;

  logic                accept;
  logic                signed1, signed2, neg1, neg2;
  logic [XLEN-1:0]     mag1, mag2;
  logic                div_zero, div_ovf, special;
  logic                neg_load;

  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       rem_sh, div_diff;
  logic [2*XLEN-1:0]   div_next;

  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo_rem, div_res, fix_val;

  assign accept  = (state_q == IDLE) && start && !kill;

  // funct3: 001 MULH, 010 MULHSU, 100 DIV, 110 REM treat rs1 as signed
  assign signed1 = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
  assign signed2 = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign neg1    = signed1 && rs1[XLEN-1];
  assign neg2    = signed2 && rs2[XLEN-1];
  assign mag1    = neg1 ? -rs1 : rs1;
  assign mag2    = neg2 ? -rs2 : rs2;

  assign div_zero = funct3[2] && (rs2 == '0);
  assign div_ovf  = funct3[2] && !funct3[0] && (rs1 == INT_MIN) && (rs2 == '1);
  assign special  = div_zero || div_ovf;

  // Remainder follows the dividend; product and quotient follow the sign product.
  assign neg_load = (funct3[2] && funct3[1]) ? neg1 : (neg1 ^ neg2);

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : {XLEN{1'b0}})};
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left.
  assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = rem_sh - {1'b0, b_q};
  assign div_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  assign prod    = neg_q ? -acc_q : acc_q;
  assign quo_rem = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign div_res = neg_q ? -quo_rem : quo_rem;
  assign fix_val = op_q[2] ? div_res :
                   (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? FIX : CALC;
      CALC: begin
        if (kill)                    state_d = IDLE;
        else if (cnt_q == LAST_ITER) state_d = FIX;
      end
      FIX:  state_d = kill ? IDLE : DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      valid  <= 1'b0;
      result <= '0;
    end else begin
      valid <= (state_q == FIX) && !kill;
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= funct3;
            cnt_q <= '0;
            // Special cases preload acc so FIX yields the mandated values unchanged.
            if (div_zero) begin
              neg_q <= 1'b0;
              b_q   <= rs2;
              acc_q <= {rs1, {XLEN{1'b1}}};
            end else if (div_ovf) begin
              neg_q <= 1'b0;
              b_q   <= rs2;
              acc_q <= {{XLEN{1'b0}}, rs1};
            end else if (funct3[2]) begin
              neg_q <= neg_load;
              b_q   <= mag2;
              acc_q <= {{XLEN{1'b0}}, mag1};
            end else begin
              neg_q <= neg_load;
              b_q   <= mag1;
              acc_q <= {{XLEN{1'b0}}, mag2};
            end
          end
        end
        CALC: begin
          if (!kill) begin
            acc_q <= op_q[2] ? div_next : mul_next;
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        FIX: begin
          if (!kill) result <= fix_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the RV32M extension. It sits in the Execute stage beside the combinational ALU and is selected for OP instructions with funct7=0000001.
- Radix-2 shift-add multiply and restoring divide; one result bit per cycle.
- Start/busy/valid handshake so the pipeline can stall on it; supports a flush (kill).

Parameters:
- XLEN, 32, operand/result width (>=8, even); 32 for RV32, 64 for RV64.
- CNTW, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  input  XLEN  operand 1 (multiplicand/dividend); sampled with start.
- rs2  input  XLEN  operand 2 (multiplier/divisor); sampled with start.
- kill  input  1  synchronous abort (pipeline flush).
- busy  output  1  high in CALC, FIX and DONE.
- valid  output  1  one-cycle result strobe.
- result  output  XLEN  result; holds its value until the next valid.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, valid=0, result=0.
  - Internal counter and accumulators cleared.
  - Any operation in progress is discarded and no valid follows.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE, start=1 at edge E0:
  - Latch funct3.
  - Latch absolute values of operands that are treated as signed: MULH both; MULHSU rs1 only; DIV/REM both.
  - Record sign of product/quotient/remainder.
  - Counter=0; go to CALC.
- Special cases bypass CALC and go IDLE->FIX at E0:
  - DIV/DIVU/REM/REMU with rs2=0: quotient = all ones; remainder = rs1.
  - DIV/REM with rs1=0x80..0 and rs2=all ones: quotient = rs1; remainder = 0.
- CALC:
  - One iteration per edge over a 2*XLEN-bit accumulator; counter increments.
  - After XLEN iterations go to FIX.
- FIX (1 edge):
  - Apply two's-complement sign correction.
  - Select the low half (MUL), high half (MULH*), quotient (DIV*) or remainder (REM*).
  - Register result; assert valid; go to DONE.
- DONE: valid=0 on the next edge; return to IDLE.
- Latency, measured from the E0 edge:
  - Normal: valid high in the cycle after edge E0+XLEN+1, i.e. XLEN+2 edges.
  - Special case: valid high in the cycle after edge E0+1 (2 edges).
  - Next start is accepted at the first edge with busy=0.
- Sign rules:
  - DIV truncates toward zero.
  - Remainder takes the sign of the dividend.
  - MULHSU treats rs2 as unsigned.
- start while busy=1: ignored; operands are not re-sampled and the current operation is unaffected.
- kill:
  - kill=1 at any edge in CALC/FIX: go to IDLE, busy=0, no valid; result keeps its previous value.
  - kill in DONE: valid still drops; no further effect.
  - kill and start together in IDLE: start is ignored.
- Signals are never X after reset; every funct3 value is defined.

Test Plan:
- Multiply (XLEN=32):
  - MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB.
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
  - Each: valid exactly 34 edges after the start edge, width 1 cycle; busy=1 in between.
- Divide:
  - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
  - REM 7/0xFFFFFFFE -> 1.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIVU 0xFFFFFFFF/0 -> 0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
  - Each: valid 2 edges after start.
- Handshake:
  - Pulse start again with different operands 5 cycles into a MUL 3*4 -> single valid with 12; second request not executed.
  - Back-to-back: start on the first cycle busy=0 -> accepted.
- Abort:
  - kill at CALC iteration 10 of DIVU 100/7 -> busy=0 next cycle, no valid, result keeps the prior value.
  - Same with rst_n pulsed low mid-CALC -> busy=0, valid=0, result=0 immediately (asynchronous).
  - Subsequent MUL 6*7 -> 42.
- Parameter: XLEN=8 build.
  - MULHU 0xFF*0xFF -> 0xFE.
  - DIV 0x80/0xFF -> 0x80.
  - Latency 10 edges.
